systolic_gemm_nxn: RTL and testbench

Parametrised NxN output-stationary systolic matrix multiplier computing C = A x B for square operand matrices.
- Generalises the fixed 2x2 multiplier: adds a start/busy/done handshake, an internal FSM and step counter, a skewed edge feeder and an NxN MAC grid with registered operand forwarding.
- Sits between the operand buffers and the result writeback path.

---
 rtl/systolic_gemm_nxn.sv | 181 ++++++++++++++++++
 tb/tb_systolic_gemm_nxn.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_gemm_nxn.sv
// systolic_gemm_nxn: NxN output-stationary systolic matrix multiplier, C = A x B.
// Start/busy/done handshake, IDLE->LOAD->RUN->DONE controller, skewed edge
// feeder and an NxN MAC grid with registered east/south operand forwarding.
// Optional build macro GEMM_SIGNED_EN: two's-complement operands, sign-extended
// products. Without it the operands are unsigned and products zero-extended.
module systolic_gemm_nxn #(
  parameter int N         = 4,
  parameter int OP_WIDTH  = 8,
  parameter int ACC_WIDTH = 2*OP_WIDTH + $clog2(N)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [N*N*OP_WIDTH-1:0]     a_mat,
  input  logic [N*N*OP_WIDTH-1:0]     b_mat,
  output logic                        busy,
  output logic                        done,
  output logic [N*N*ACC_WIDTH-1:0]    c_mat
);

  localparam int SW = $clog2(3*N);
  localparam logic [SW-1:0] LAST_STEP = SW'(3*N-3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                      state_r, next_state_s;
  logic                        accept_s;
  logic [SW-1:0]               step_r;
  logic                        busy_r, done_r;
  logic [N*N*OP_WIDTH-1:0]     a_lat_r, b_lat_r;
  logic [OP_WIDTH-1:0]         west_s  [N];
  logic [OP_WIDTH-1:0]         north_s [N];
  logic [OP_WIDTH-1:0]         a_in_s  [N][N];
  logic [OP_WIDTH-1:0]         b_in_s  [N][N];
  logic [OP_WIDTH-1:0]         a_fwd_r [N][N];
  logic [OP_WIDTH-1:0]         b_fwd_r [N][N];
  logic [ACC_WIDTH-1:0]        acc_r   [N][N];

  // Product of two operands extended to the accumulator width; truncating the
  // ACC_WIDTH-wide product keeps the result exact modulo 2^ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [OP_WIDTH-1:0] a,
                                                   input logic [OP_WIDTH-1:0] b);
    logic [ACC_WIDTH-1:0] ax;
    logic [ACC_WIDTH-1:0] bx;
`ifdef GEMM_SIGNED_EN
    ax = {{(ACC_WIDTH-OP_WIDTH){a[OP_WIDTH-1]}}, a};
    bx = {{(ACC_WIDTH-OP_WIDTH){b[OP_WIDTH-1]}}, b};
`else
    ax = {{(ACC_WIDTH-OP_WIDTH){1'b0}}, a};
    bx = {{(ACC_WIDTH-OP_WIDTH){1'b0}}, b};
`endif
    return ax * bx;
  endfunction

  // Controller next state; a start is only taken in IDLE or DONE.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_LOAD;
          accept_s     = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: next_state_s = ST_RUN;
      ST_RUN: begin
        if (step_r == LAST_STEP) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          next_state_s = ST_LOAD;
          accept_s     = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, step counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      step_r  <= {SW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      step_r  <= (state_r == ST_RUN && step_r != LAST_STEP) ? step_r + SW'(1) : {SW{1'b0}};
      busy_r  <= (next_state_s == ST_LOAD) || (next_state_s == ST_RUN);
      done_r  <= (next_state_s == ST_DONE);
    end
  end

  // Skewed edge feeder: row i sees A[i][t-i], column j sees B[t-j][j], else 0.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      west_s[i]  = {OP_WIDTH{1'b0}};
      north_s[i] = {OP_WIDTH{1'b0}};
      for (int k = 0; k < N; k++) begin
        if (step_r == SW'(i + k)) begin
          west_s[i]  = a_lat_r[(i*N+k)*OP_WIDTH +: OP_WIDTH];
          north_s[i] = b_lat_r[(k*N+i)*OP_WIDTH +: OP_WIDTH];
        end else begin
          west_s[i]  = west_s[i];
          north_s[i] = north_s[i];
        end
      end
    end
  end

  // Grid wiring: first column/row take the edge feed, others the neighbour hop.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_west
        assign a_in_s[gi][gj] = west_s[gi];
      end else begin : g_ahop
        assign a_in_s[gi][gj] = a_fwd_r[gi][gj-1];
      end
      if (gi == 0) begin : g_north
        assign b_in_s[gi][gj] = north_s[gj];
      end else begin : g_bhop
        assign b_in_s[gi][gj] = b_fwd_r[gi-1][gj];
      end
      assign c_mat[(gi*N+gj)*ACC_WIDTH +: ACC_WIDTH] = acc_r[gi][gj];
    end
  end

  // Operand latches, PE accumulators and forwarding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_lat_r <= {(N*N*OP_WIDTH){1'b0}};
      b_lat_r <= {(N*N*OP_WIDTH){1'b0}};
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_r[i][j]   <= {ACC_WIDTH{1'b0}};
          a_fwd_r[i][j] <= {OP_WIDTH{1'b0}};
          b_fwd_r[i][j] <= {OP_WIDTH{1'b0}};
        end
      end
    end else begin
      if (accept_s) begin
        a_lat_r <= a_mat;
        b_lat_r <= b_mat;
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (accept_s) begin
            acc_r[i][j] <= {ACC_WIDTH{1'b0}};
          end else if (state_r == ST_RUN) begin
            acc_r[i][j] <= acc_r[i][j] + mul_ext(a_in_s[i][j], b_in_s[i][j]);
          end
          if (state_r == ST_LOAD) begin
            a_fwd_r[i][j] <= {OP_WIDTH{1'b0}};
            b_fwd_r[i][j] <= {OP_WIDTH{1'b0}};
          end else if (state_r == ST_RUN) begin
            a_fwd_r[i][j] <= a_in_s[i][j];
            b_fwd_r[i][j] <= b_in_s[i][j];
          end
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_systolic_gemm_nxn.sv
// Scoreboard bench for systolic_gemm_nxn: one N=2 and one N=4 instance.
// Stimulus pushes the hand-computed C and the expected done cycle; monitors
// pop and compare whenever done rises. Build with GEMM_SIGNED_EN for the
// signed vectors.
module tb_systolic_gemm_nxn;

  localparam int C2W = 17;
  localparam int C4W = 18;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              start2, busy2, done2;
  logic [31:0]       a2, b2;
  logic [4*C2W-1:0]  c2;
  logic              start4, busy4, done4;
  logic [127:0]      a4, b4;
  logic [16*C4W-1:0] c4;

  int errors = 0;
  int checks = 0;
  logic [4*C2W-1:0]  exp2_q[$];
  int                t2_q[$];
  logic [16*C4W-1:0] exp4_q[$];
  int                t4_q[$];

  systolic_gemm_nxn #(.N(2), .OP_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a_mat(a2), .b_mat(b2),
    .busy(busy2), .done(done2), .c_mat(c2));

  systolic_gemm_nxn #(.N(4), .OP_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a_mat(a4), .b_mat(b4),
    .busy(busy4), .done(done4), .c_mat(c4));

  task automatic check(input string name, input logic [287:0] got, input logic [287:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  function automatic logic [127:0] fill4(input logic [7:0] v);
    logic [127:0] m;
    for (int k = 0; k < 16; k++) m[k*8 +: 8] = v;
    return m;
  endfunction

  function automatic logic [287:0] cfill4(input logic [17:0] v);
    logic [287:0] m;
    for (int k = 0; k < 16; k++) m[k*18 +: 18] = v;
    return m;
  endfunction

  function automatic logic [127:0] ident4();
    logic [127:0] m;
    m = 128'd0;
    for (int r = 0; r < 4; r++) m[(r*4+r)*8 +: 8] = 8'd1;
    return m;
  endfunction

  function automatic logic [127:0] ramp4();
    logic [127:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[(r*4+c)*8 +: 8] = 8'(4*r + c);
    return m;
  endfunction

  function automatic logic [287:0] cramp4();
    logic [287:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[(r*4+c)*18 +: 18] = 18'(4*r + c);
    return m;
  endfunction

  // all-ones A times ramp B: C[i][j] = sum_k (4k+j) = 24 + 4j
  function automatic logic [287:0] cones_ramp4();
    logic [287:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[(r*4+c)*18 +: 18] = 18'(24 + 4*c);
    return m;
  endfunction

  task automatic go2(input logic [31:0] a, input logic [31:0] b, input logic [4*C2W-1:0] e);
    a2 = a; b2 = b; start2 = 1'b1;
    exp2_q.push_back(e);
    t2_q.push_back(cyc + 6);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic go4(input logic [127:0] a, input logic [127:0] b, input logic [16*C4W-1:0] e);
    a4 = a; b4 = b; start4 = 1'b1;
    exp4_q.push_back(e);
    t4_q.push_back(cyc + 12);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done4();
    int n;
    n = 0;
    while (!done4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done4_seen", 288'(done4), 288'(1));
  endtask

  // N=2 monitor: result and latency on every done pulse
  always @(negedge clk) begin
    if (!reset) begin
      check("busy_done_excl2", 288'(busy2 & done2), 288'(0));
      if (done2) begin
        if (exp2_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done2_unexpected: got done=1 expected no pending job");
        end else begin
          check("c2", 288'(c2), 288'(exp2_q.pop_front()));
          check("lat2", 288'(cyc), 288'(t2_q.pop_front()));
        end
      end
    end
  end

  // N=4 monitor: result and latency on every done pulse
  always @(negedge clk) begin
    if (!reset) begin
      check("busy_done_excl4", 288'(busy4 & done4), 288'(0));
      if (done4) begin
        if (exp4_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done4_unexpected: got done=1 expected no pending job");
        end else begin
          check("c4", c4, exp4_q.pop_front());
          check("lat4", 288'(cyc), 288'(t4_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int guard;
    bit seen;
    reset = 1'b1; start2 = 1'b0; start4 = 1'b0;
    a2 = 32'd0; b2 = 32'd0; a4 = 128'd0; b4 = 128'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy2", 288'(busy2), 288'(0));
    check("rst_done2", 288'(done2), 288'(0));
    check("rst_c2", 288'(c2), 288'(0));
    check("rst_busy4", 288'(busy4), 288'(0));
    check("rst_done4", 288'(done4), 288'(0));
    check("rst_c4", c4, 288'(0));
    @(negedge clk);

    // N=2 worked example, plus busy length 3N-1 = 5
    go2({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5},
        {17'd50, 17'd43, 17'd22, 17'd19});
    n = 0; guard = 0;
    while (!done2 && guard < 30) begin
      if (busy2) n++;
      @(negedge clk);
      guard++;
    end
    check("done2_seen", 288'(done2), 288'(1));
    check("busy2_cycles", 288'(n), 288'(5));
    @(negedge clk);

    // identity x ramp = ramp
    go4(ident4(), ramp4(), cramp4());
    wait_done4();
    @(negedge clk);

`ifdef GEMM_SIGNED_EN
    go4(fill4(8'h80), fill4(8'h80), cfill4(18'd65536));
    wait_done4();
    @(negedge clk);
    go4(fill4(8'hFF), fill4(8'h01), cfill4(18'h3FFFC));
    wait_done4();
    @(negedge clk);
`else
    go4(fill4(8'hFF), fill4(8'hFF), cfill4(18'd260100));
    wait_done4();
    @(negedge clk);
`endif

    // start during RUN with new operands must be ignored
    go4(fill4(8'd1), ramp4(), cones_ramp4());
    repeat (3) @(negedge clk);
    a4 = fill4(8'd7); b4 = ident4(); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("busy4_ignored_start", 288'(busy4), 288'(1));
    wait_done4();
    @(negedge clk);

    // reset at RUN step 2: back to IDLE, cleared result, no done
    a4 = ident4(); b4 = ramp4(); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    check("busy4_step2", 288'(busy4), 288'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy4", 288'(busy4), 288'(0));
    check("mid_rst_done4", 288'(done4), 288'(0));
    check("mid_rst_c4", c4, 288'(0));
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    check("no_done_after_reset", 288'(seen), 288'(0));
    go4(ident4(), fill4(8'd3), cfill4(18'd3));
    wait_done4();
    @(negedge clk);

    // back-to-back: start during DONE
    go4(fill4(8'd2), ident4(), cfill4(18'd2));
    wait_done4();
    go4(ramp4(), ident4(), cramp4());
    check("b2b_busy4_load", 288'(busy4), 288'(1));
    check("b2b_c4_cleared", c4, 288'(0));
    wait_done4();
    @(negedge clk);
    @(negedge clk);

    check("q2_drained", 288'(exp2_q.size()), 288'(0));
    check("q4_drained", 288'(exp4_q.size()), 288'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
